if_prefetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined RV32I core, replacing the single IF/ID fetch latch.
- Issues word fetches to the shared instruction/data memory port, which the MEM stage may deny.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to the decode stage through a valid/ready handshake.
- Flushes all wrong-path state on a branch/jump redirect from EX/MEM.

---
 rtl/if_prefetch_queue_if.sv | 51 +++++
 rtl/if_prefetch_queue.sv | 152 +++++++++++++++
 tb/tb_if_prefetch_queue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue_if
//   Bundles the fetch-side memory port, the decode handshake and the
//   redirect signals of the instruction prefetch queue.
//
//   Parameters: XLEN (PC/address width), DEPTH (queue entries, sizes count_o)
//
//   Signals:
//     imem_req_o / imem_addr_o        fetch request and word address
//     imem_gnt_i                      memory accepts the request this cycle
//     imem_rvalid_i / imem_rdata_i    fetch data, one cycle after the grant
//     inst_valid_o / inst_o / inst_pc_o / inst_ready_i
//                                     decode handshake and head entry
//     redirect_i / redirect_pc_i      taken branch/jump and its target
//     count_o                         queue occupancy
//
//   Modports:
//     master  the prefetch queue itself
//     slave   the environment (memory port, decode stage, EX/MEM redirect)
// ---------------------------------------------------------------------------
interface if_prefetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             imem_req_o;
    logic [XLEN-1:0]  imem_addr_o;
    logic             imem_gnt_i;
    logic             imem_rvalid_i;
    logic [31:0]      imem_rdata_i;
    logic             inst_valid_o;
    logic [31:0]      inst_o;
    logic [XLEN-1:0]  inst_pc_o;
    logic             inst_ready_i;
    logic             redirect_i;
    logic [XLEN-1:0]  redirect_pc_i;
    logic [CNT_W-1:0] count_o;

    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, count_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
               redirect_i, redirect_pc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, count_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
               redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
//   Instruction-fetch front end for the pipelined RV32I core. Issues word
//   fetches to the shared memory port (which may deny them), buffers the
//   returned instructions with their PCs in a DEPTH-entry FIFO and hands
//   them to decode through a valid/ready handshake. A redirect flushes the
//   queue and the in-flight fetch and restarts fetching at the target.
//
//   Parameters:
//     XLEN      PC/address width
//     DEPTH     FIFO entries, power of two >= 2 (>= 3 for one inst/cycle)
//     RESET_PC  first fetch address after reset
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     bus   if_prefetch_queue_if.master (memory port, decode, redirect)
//
//   Build option:
//     PREFETCH_BYPASS_EN  when defined, a response arriving while the FIFO
//                         is empty is presented to decode in the same cycle
//                         (and only written if decode does not take it).
// ---------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    if_prefetch_queue_if.master   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_L    = (CNT_W + 1)'(DEPTH);
    localparam logic [XLEN-1:0]   RESET_PC_A = {RESET_PC[XLEN-1:2], 2'b00};

    // Control state (reset)
    logic [XLEN-1:0]  fetch_pc;
    logic             pending_p1;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Data state (no reset)
    logic [XLEN-1:0]  req_pc_p1;
    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];

    logic             redirect;
    logic [CNT_W:0]   inflight;
    logic             req;
    logic             fire;
    logic             accept;
    logic             fifo_empty;
    logic             head_vld;
    logic             push;
    logic             pop;
    logic             inst_valid;
    logic [31:0]      inst;
    logic [XLEN-1:0]  inst_pc;
    logic             unused_bits;

    // Low two bits of the redirect target are dropped by construction.
    assign unused_bits = &{1'b0, bus.redirect_pc_i[1:0]};

    assign redirect = bus.redirect_i;

    // Room check counts buffered entries plus the outstanding fetch and
    // deliberately ignores a pop in the same cycle, keeping the request
    // path independent of decode's ready.
    assign inflight   = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_p1};
    assign req        = rst && !redirect && (inflight < DEPTH_L);
    assign fire       = req && bus.imem_gnt_i;

    // Data with no outstanding fetch is stray and never enters the queue.
    assign accept     = bus.imem_rvalid_i && pending_p1 && !redirect;

    assign fifo_empty = (count_q == '0);
    assign head_vld   = rst && !redirect && !fifo_empty;
    assign pop        = head_vld && bus.inst_ready_i;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;

    // A response landing on an empty queue goes straight to decode; it is
    // only stored when decode stalls this cycle.
    assign bypass     = accept && fifo_empty;
    assign inst_valid = head_vld || bypass;
    assign inst       = bypass ? bus.imem_rdata_i : inst_mem[rd_ptr];
    assign inst_pc    = bypass ? req_pc_p1        : pc_mem[rd_ptr];
    assign push       = accept && !(bypass && bus.inst_ready_i);
`else
    assign inst_valid = head_vld;
    assign inst       = inst_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];
    assign push       = accept;
`endif

    assign bus.imem_req_o   = req;
    assign bus.imem_addr_o  = fetch_pc;
    assign bus.inst_valid_o = inst_valid;
    assign bus.inst_o       = inst;
    assign bus.inst_pc_o    = inst_pc;
    assign bus.count_o      = count_q;

    // ---- stage p0 -> p1: request issue, pointer and occupancy update ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC_A;
            pending_p1 <= 1'b0;
            count_q    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else if (redirect) begin
            fetch_pc   <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
            pending_p1 <= 1'b0;
            count_q    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            // A denied request leaves nothing outstanding; it is retried
            // from the unchanged fetch_pc next cycle.
            pending_p1 <= fire;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---- stage p1 -> queue: capture request PC, write returned entry ----
    always_ff @(posedge clk) begin
        if (fire) begin
            req_pc_p1 <= fetch_pc;
        end
        if (push) begin
            pc_mem[wr_ptr]   <= req_pc_p1;
            inst_mem[wr_ptr] <= bus.imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    if_prefetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data returns exactly one cycle after a granted request.
    logic        rv_q;
    logic [31:0] ad_q;
    always @(posedge clk) begin
        rv_q <= bus.imem_req_o && bus.imem_gnt_i;
        ad_q <= bus.imem_addr_o;
    end

    function automatic logic [31:0] f_inst(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        gnt;
        logic        rdy;
        logic        rdr;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t v(input logic g, input logic r, input logic d,
                               input logic [31:0] rp, input logic q,
                               input logic [31:0] a, input logic vl,
                               input logic [31:0] p, input logic [2:0] c);
        vec_t t;
        t.gnt = g; t.rdy = r; t.rdr = d; t.rpc = rp;
        t.ereq = q; t.eaddr = a; t.evld = vl; t.epc = p; t.ecnt = c;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, settle, then compare.
    task automatic step(input logic g, input logic r, input logic d,
                        input logic [31:0] rp, input logic stray);
        @(negedge clk);
        bus.imem_gnt_i    = g;
        bus.inst_ready_i  = r;
        bus.redirect_i    = d;
        bus.redirect_pc_i = rp;
        bus.imem_rvalid_i = rv_q | stray;
        bus.imem_rdata_i  = rv_q ? f_inst(ad_q) : 32'hBAD0_BAD0;
        #1;
    endtask

    task automatic expect_out(input string nm, input int idx, input logic q,
                              input logic [31:0] a, input logic vl,
                              input logic [31:0] p, input logic [2:0] c);
        chk({nm, "_req"},   idx, {31'b0, bus.imem_req_o}, {31'b0, q});
        chk({nm, "_addr"},  idx, bus.imem_addr_o, a);
        chk({nm, "_valid"}, idx, {31'b0, bus.inst_valid_o}, {31'b0, vl});
        chk({nm, "_count"}, idx, {29'b0, bus.count_o}, {29'b0, c});
        if (vl) begin
            chk({nm, "_pc"},   idx, bus.inst_pc_o, p);
            chk({nm, "_inst"}, idx, bus.inst_o, f_inst(p));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b0;
        bus.imem_gnt_i    = 1'b1;
        bus.inst_ready_i  = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;

        // Held in reset with grant and ready high: nothing may be issued.
        repeat (2) @(negedge clk);
        #1;
        expect_out("reset", 0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        // Release with gnt low so the first edge issues nothing.
        bus.imem_gnt_i = 1'b0;
        rst = 1'b1;

`ifndef PREFETCH_BYPASS_EN
        //            gnt   rdy   rdr   rpc          req   addr         vld   pc           cnt
        tbl[0]  = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   3'd0);
        tbl[1]  = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   3'd0);
        tbl[2]  = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0,   3'd1);
        tbl[3]  = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h4,   3'd1);
        tbl[4]  = v(1'b1, 1'b1, 1'b1, 32'h1,   1'b0, 32'h10,  1'b0, 32'h0,   3'd1);
        tbl[5]  = v(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   3'd0);
        tbl[6]  = v(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   3'd0);
        tbl[7]  = v(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0,   3'd1);
        tbl[8]  = v(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h0,   3'd2);
        tbl[9]  = v(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0,   3'd3);
        tbl[10] = v(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0,   3'd4);
        tbl[11] = v(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0,   3'd4);
        tbl[12] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0,   3'd4);
        tbl[13] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h4,   3'd3);
        tbl[14] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h8,   3'd2);
        tbl[15] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'hC,   3'd2);
        tbl[16] = v(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h10,  3'd2);
        tbl[17] = v(1'b1, 1'b0, 1'b1, 32'h103, 1'b0, 32'h20,  1'b0, 32'h0,   3'd3);
        tbl[18] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   3'd0);
        tbl[19] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   3'd0);
        tbl[20] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 3'd1);
        tbl[21] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104, 3'd1);
        tbl[22] = v(1'b1, 1'b1, 1'b1, 32'h0,   1'b0, 32'h110, 1'b0, 32'h0,   3'd1);
        tbl[23] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   3'd0);
        tbl[24] = v(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   3'd0);
        tbl[25] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   3'd1);
        tbl[26] = v(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0,   3'd0);
        tbl[27] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   3'd1);
        tbl[28] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0, 32'h0,   3'd0);
        tbl[29] = v(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8,   3'd1);

        for (int i = 0; i < 30; i++) begin
            step(tbl[i].gnt, tbl[i].rdy, tbl[i].rdr, tbl[i].rpc, 1'b0);
            expect_out("vec", i, tbl[i].ereq, tbl[i].eaddr, tbl[i].evld,
                       tbl[i].epc, tbl[i].ecnt);
        end

        // Drain with grants denied, then a stray rvalid with nothing pending.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("drain", 0, 1'b1, 32'h14, 1'b1, 32'hC, 3'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("drain", 1, 1'b1, 32'h14, 1'b1, 32'h10, 3'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        expect_out("stray", 0, 1'b1, 32'h14, 1'b0, 32'h0, 3'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("stray", 1, 1'b1, 32'h14, 1'b0, 32'h0, 3'd0);

        // Buffer two entries, then pulse reset mid-cycle.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_out("fill", 0, 1'b1, 32'h14, 1'b0, 32'h0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_out("fill", 1, 1'b1, 32'h18, 1'b0, 32'h0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_out("fill", 2, 1'b1, 32'h1C, 1'b1, 32'h14, 3'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("fill", 3, 1'b1, 32'h20, 1'b1, 32'h14, 3'd2);
        #1;
        rst = 1'b0;
        #1;
        expect_out("async_rst", 0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("async_rst", 1, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        bus.imem_gnt_i = 1'b0;
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("restart", 0, 1'b1, 32'h0, 1'b0, 32'h0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("restart", 1, 1'b1, 32'h4, 1'b0, 32'h0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("restart", 2, 1'b1, 32'h8, 1'b1, 32'h0, 3'd1);
`else
        // Bypass: an empty queue presents the response in its own cycle.
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("byp", 0, 1'b1, 32'h0, 1'b0, 32'h0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("byp", 1, 1'b1, 32'h4, 1'b1, 32'h0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("byp", 2, 1'b1, 32'h8, 1'b1, 32'h4, 3'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_out("byp", 3, 1'b1, 32'hC, 1'b1, 32'h8, 3'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_out("byp", 4, 1'b1, 32'h10, 1'b1, 32'h8, 3'd1);
        step(1'b1, 1'b1, 1'b1, 32'h42, 1'b0);
        expect_out("byp_rdr", 0, 1'b0, 32'h14, 1'b0, 32'h0, 3'd2);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("byp_rdr", 1, 1'b1, 32'h40, 1'b0, 32'h0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_out("byp_rdr", 2, 1'b1, 32'h44, 1'b1, 32'h40, 3'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
